// File: rtl/regfile_dump_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_dump_engine_pkg
//  Purpose  : Shared processor constants for the register-file dump path:
//             default register-file geometry and the dump FSM state codes.
//             The state codes live here so the trace unit can decode a
//             debug tap of the engine state.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package regfile_dump_engine_pkg;

  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_DATA_W   = 32;

  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] dumpState_t;

  localparam dumpState_t c_ST_IDLE   = 3'd0;
  localparam dumpState_t c_ST_ISSUE  = 3'd1;
  localparam dumpState_t c_ST_SEND_A = 3'd2;
  localparam dumpState_t c_ST_SEND_B = 3'd3;
  localparam dumpState_t c_ST_DONE   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/regfile_dump_engine.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_dump_engine
//  Purpose  : Debug readout engine on the two regfile read ports. On a start
//             pulse it walks all registers as even/odd pairs, snapshots each
//             pair in one ISSUE cycle, then streams {index, value} beats over
//             valid/ready and pulses dump_done after the last beat.
//  Ports    : clock, ctrl_reset         - clock, sync active-high reset
//             start, busy               - request / activity status
//             ctrl_readRegA/B           - regfile read addresses (even/odd)
//             data_readRegA/B           - regfile read data
//             dump_valid/ready/index/data - beat stream to trace unit
//             dump_done                 - one-cycle completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_dump_engine
  import regfile_dump_engine_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              start,
  output logic              busy,
  output logic [ADDR_W-1:0] ctrl_readRegA,
  output logic [ADDR_W-1:0] ctrl_readRegB,
  input  logic [DATA_W-1:0] data_readRegA,
  input  logic [DATA_W-1:0] data_readRegB,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_index,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done
);

  localparam logic [ADDR_W-2:0] c_LAST_PAIR = (ADDR_W-1)'(NUM_REGS/2 - 1);

  dumpState_t        r_state;
  logic [ADDR_W-2:0] r_pair;
  logic [DATA_W-1:0] r_bufA;
  logic [DATA_W-1:0] r_bufB;
  logic [ADDR_W-1:0] r_readA;
  logic [ADDR_W-1:0] r_readB;

  dumpState_t        w_nextState;
  logic [ADDR_W-2:0] w_nextPair;
  logic              w_addrActive;

  always_comb begin
    w_nextState = r_state;
    w_nextPair  = r_pair;
    case (r_state)
      c_ST_IDLE: begin
        if (start) begin
          w_nextState = c_ST_ISSUE;
          w_nextPair  = '0;
        end
      end
      c_ST_ISSUE:  w_nextState = c_ST_SEND_A;
      c_ST_SEND_A: if (dump_ready) w_nextState = c_ST_SEND_B;
      c_ST_SEND_B: begin
        if (dump_ready) begin
          if (r_pair == c_LAST_PAIR) begin
            w_nextState = c_ST_DONE;
          end else begin
            w_nextPair  = r_pair + 1'b1;
            w_nextState = c_ST_ISSUE;
          end
        end
      end
      c_ST_DONE:   w_nextState = c_ST_IDLE;
      default:     w_nextState = c_ST_IDLE;
    endcase
    // Addresses are flopped from the next-state view so they are already
    // valid during the ISSUE cycle they feed.
    w_addrActive = (w_nextState == c_ST_ISSUE) || (w_nextState == c_ST_SEND_A) ||
                   (w_nextState == c_ST_SEND_B);
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      r_state <= c_ST_IDLE;
      r_pair  <= '0;
      r_bufA  <= '0;
      r_bufB  <= '0;
      r_readA <= '0;
      r_readB <= '0;
    end else begin
      r_state <= w_nextState;
      r_pair  <= w_nextPair;
      // Snapshot point: a regfile write landing on this same edge is not seen.
      if (r_state == c_ST_ISSUE) begin
        r_bufA <= data_readRegA;
        r_bufB <= data_readRegB;
      end
      r_readA <= w_addrActive ? {w_nextPair, 1'b0} : '0;
      r_readB <= w_addrActive ? {w_nextPair, 1'b1} : '0;
    end
  end

  always_comb begin
    dump_valid = 1'b0;
    dump_index = '0;
    dump_data  = '0;
    case (r_state)
      c_ST_SEND_A: begin
        dump_valid = 1'b1;
        dump_index = {r_pair, 1'b0};
        dump_data  = r_bufA;
      end
      c_ST_SEND_B: begin
        dump_valid = 1'b1;
        dump_index = {r_pair, 1'b1};
        dump_data  = r_bufB;
      end
      default: ;
    endcase
  end

  assign busy          = (r_state != c_ST_IDLE);
  assign dump_done     = (r_state == c_ST_DONE);
  assign ctrl_readRegA = r_readA;
  assign ctrl_readRegB = r_readB;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_dump_engine
//  Purpose  : Self-checking bench for regfile_dump_engine with a behavioural
//             regfile (one write port, two combinational read ports).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_dump_engine;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        start;
  logic        busy;
  logic [4:0]  ctrl_readRegA, ctrl_readRegB;
  logic [31:0] data_readRegA, data_readRegB;
  logic        dump_valid, dump_ready, dump_done;
  logic [4:0]  dump_index;
  logic [31:0] dump_data;

  logic        wrEn;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;
  logic [31:0] rf [32];
  logic [31:0] expReg [32];

  int nChecks;
  int nPass;

  always #5 clock = ~clock;

  regfile_dump_engine dut (
    .clock         (clock),
    .ctrl_reset    (ctrl_reset),
    .start         (start),
    .busy          (busy),
    .ctrl_readRegA (ctrl_readRegA),
    .ctrl_readRegB (ctrl_readRegB),
    .data_readRegA (data_readRegA),
    .data_readRegB (data_readRegB),
    .dump_valid    (dump_valid),
    .dump_ready    (dump_ready),
    .dump_index    (dump_index),
    .dump_data     (dump_data),
    .dump_done     (dump_done)
  );

  // Behavioural regfile: register 0 is never written.
  always @(posedge clock) begin
    if (wrEn && (wrAddr != 5'd0)) rf[wrAddr] <= wrData;
  end
  assign data_readRegA = rf[ctrl_readRegA];
  assign data_readRegB = rf[ctrl_readRegB];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One dump from start to the cycle after DONE, sampled on negedges.
  task automatic runDump(input bit bp, input bit restart, input int cwPair,
                         output int beats, output int doneCnt, output int busyCnt);
    int cyc, phase, firstValid;
    bit prevValid, prevAcc, restartDone, cwFired, doneSeen, acc;
    logic [4:0]  prevIdx;
    logic [31:0] prevData;
    beats = 0; doneCnt = 0; busyCnt = 0; cyc = 0; phase = 0; firstValid = -1;
    prevValid = 0; prevAcc = 0; restartDone = 0; cwFired = 0; doneSeen = 0;
    prevIdx = '0; prevData = '0;
    @(negedge clock); start = 1'b1;
    @(negedge clock);
    while (cyc < 3000) begin
      cyc++;
      wrEn  = 1'b0;
      start = 1'b0;
      if (doneSeen) begin
        check("idleAfterDone", busy, 0);
        check("noValidAfterDone", dump_valid, 0);
        break;
      end
      if (busy) busyCnt++;
      if (dump_valid && firstValid < 0) firstValid = cyc;
      if (prevValid && !prevAcc) begin
        check("holdValid", dump_valid, 1);
        check("holdIdx", dump_index, prevIdx);
        check("holdData", dump_data, prevData);
      end
      if (!dump_valid) begin
        check("zeroIdx", dump_index, 0);
        check("zeroData", dump_data, 0);
      end
      dump_ready = bp ? (phase == 2) : 1'b1;
      phase = (phase + 1) % 3;
      acc = dump_valid && dump_ready;
      if (acc) begin
        if (beats < 32) begin
          check("beatIdx", dump_index, beats[4:0]);
          check("beatData", dump_data, expReg[beats]);
        end else begin
          check("extraBeat", beats, 31);
        end
        beats++;
      end
      prevValid = dump_valid; prevAcc = acc; prevIdx = dump_index; prevData = dump_data;
      if (restart && !restartDone && beats == 10 && dump_valid) begin
        start = 1'b1;
        restartDone = 1'b1;
      end
      if (cwPair >= 0 && !cwFired && busy && !dump_valid && !dump_done &&
          ctrl_readRegA == 5'(2*cwPair)) begin
        wrEn = 1'b1; wrAddr = 5'd7; wrData = 32'hBEEF0007; cwFired = 1'b1;
      end
      if (dump_done) begin
        doneCnt++;
        doneSeen = 1'b1;
        check("doneAfterLast", beats, 32);
        if (restart) start = 1'b1;
      end
      @(negedge clock);
    end
    start = 1'b0;
    dump_ready = 1'b0;
    if (!doneSeen) check("doneTimeout", 0, 1);
    check("firstValidLat", firstValid, 2);
    if (cwPair >= 0) check("cwFired", cwFired, 1);
  endtask

  initial begin
    int beats, doneCnt, busyCnt;
    bit found, quiet;
    nChecks = 0; nPass = 0;
    ctrl_reset = 1'b1; start = 1'b0; dump_ready = 1'b0;
    wrEn = 1'b0; wrAddr = '0; wrData = '0;
    for (int i = 0; i < 32; i++) begin
      rf[i] = '0;
      expReg[i] = (i == 0) ? 32'h0 : 32'h0000DEAD + i;
    end
    repeat (3) @(negedge clock);
    check("rstBusy", busy, 0);
    check("rstValid", dump_valid, 0);
    check("rstDone", dump_done, 0);
    check("rstIdx", dump_index, 0);
    check("rstData", dump_data, 0);
    check("rstAddrA", ctrl_readRegA, 0);
    check("rstAddrB", ctrl_readRegB, 0);
    ctrl_reset = 1'b0;

    for (int i = 1; i < 32; i++) begin
      wrEn = 1'b1; wrAddr = i[4:0]; wrData = 32'h0000DEAD + i;
      @(negedge clock);
    end
    wrEn = 1'b0;

    // Full dump, no backpressure.
    runDump(1'b0, 1'b0, -1, beats, doneCnt, busyCnt);
    check("fullBeats", beats, 32);
    check("fullDoneCnt", doneCnt, 1);
    check("fullBusyCycles", busyCnt, 49);

    // Backpressure 0,0,1.
    runDump(1'b1, 1'b0, -1, beats, doneCnt, busyCnt);
    check("bpBeats", beats, 32);
    check("bpDoneCnt", doneCnt, 1);

    // Start while busy and in DONE.
    runDump(1'b0, 1'b1, -1, beats, doneCnt, busyCnt);
    check("rsBeats", beats, 32);
    check("rsDoneCnt", doneCnt, 1);
    check("rsBusyCycles", busyCnt, 49);

    // Reset during SEND_B of pair 5 (index 11).
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0; dump_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (dump_valid && dump_index == 5'd11) begin
        found = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("rstMidFound", found, 1);
    ctrl_reset = 1'b1;
    @(negedge clock);
    ctrl_reset = 1'b0; dump_ready = 1'b0;
    check("midBusy", busy, 0);
    check("midValid", dump_valid, 0);
    check("midDone", dump_done, 0);
    check("midIdx", dump_index, 0);
    check("midData", dump_data, 0);
    check("midAddrA", ctrl_readRegA, 0);
    check("midAddrB", ctrl_readRegB, 0);
    quiet = 1'b1;
    repeat (5) begin
      @(negedge clock);
      if (dump_done || busy) quiet = 1'b0;
    end
    check("midQuiet", quiet, 1);
    runDump(1'b0, 1'b0, -1, beats, doneCnt, busyCnt);
    check("postRstBeats", beats, 32);
    check("postRstDone", doneCnt, 1);

    // Write to reg 7 on the edge closing ISSUE of pair 3: old value reported.
    runDump(1'b0, 1'b0, 3, beats, doneCnt, busyCnt);
    check("cwBeats", beats, 32);
    expReg[7] = 32'hBEEF0007;
    runDump(1'b0, 1'b0, -1, beats, doneCnt, busyCnt);
    check("cw2Beats", beats, 32);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
